aes_core_arbiter: RTL

//  Shares one AES core among NUM_REQ requesters: round-robin arbitration, key-load and block

---
 rtl/aes_pkg.sv | 10 +
 rtl/aes_core_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/aes_core_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: FSM state encoding and default key identifier width shared by the AES core arbiter
package aes_pkg;
    localparam int KEY_ID_W_DEF = 2;
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LD_KEY      = 3'd1;
    localparam logic [2:0] S_KINIT       = 3'd2;
    localparam logic [2:0] S_WAIT_KEY    = 3'd3;
    localparam logic [2:0] S_LD_TEXT     = 3'd4;
    localparam logic [2:0] S_WAIT_CIPHER = 3'd5;
endpackage

// File: rtl/aes_core_arbiter_if.sv
// aes_core_arbiter_if: requester and AES core handshake bundle; slave is the arbiter view
interface aes_core_arbiter_if
    import aes_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int KEY_ID_W = KEY_ID_W_DEF
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*KEY_ID_W-1:0] key_id;
    logic [NUM_REQ-1:0]          grant;
    logic [$clog2(NUM_REQ)-1:0]  sel;
    logic [NUM_REQ-1:0]          done;
    logic                        en_key;
    logic                        en_data;
    logic                        core_init;
    logic                        core_next;
    logic                        core_ready;
    logic                        core_valid;
    modport slave (
        input  req, key_id, core_ready, core_valid,
        output grant, sel, done, en_key, en_data, core_init, core_next
    );
    modport master (
        output req, key_id, core_ready, core_valid,
        input  grant, sel, done, en_key, en_data, core_init, core_next
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: first set request at or above ptr (wrapping), as one-hot grant and index
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] j;
    // Scan from the farthest offset down so the nearest hit is the final assignment
    always_comb begin
        j   = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (req[j]) idx = j;
        end
        any      = |req;
        gnt      = '0;
        gnt[idx] = any;
    end
endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sharing of one AES core with key-load and block sequencing.
// Define AES_KEY_CACHE_EN to skip the key reload when the winner's key_id matches the last loaded key.
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int KEY_ID_W = KEY_ID_W_DEF
) (
    input logic               clk,
    input logic               rst,
    aes_core_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, arb_gnt;
    logic [IW-1:0]      sel_q, sel_d, ptr_q, ptr_d, arb_idx;
    logic               arb_any, hit, core_next_q, core_next_d;
    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req(bus.req),
        .ptr(ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );
`ifdef AES_KEY_CACHE_EN
    logic [KEY_ID_W-1:0] cache_id_q, cache_id_d;
    logic                cache_vld_q, cache_vld_d;
    always_comb begin
        cache_id_d  = (state_q == S_LD_KEY) ? bus.key_id[sel_q*KEY_ID_W +: KEY_ID_W] : cache_id_q;
        cache_vld_d = cache_vld_q || state_q == S_LD_KEY;
        hit         = cache_vld_q && cache_id_q == bus.key_id[arb_idx*KEY_ID_W +: KEY_ID_W];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_id_q  <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_id_q  <= cache_id_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    logic [KEY_ID_W-1:0] unused_key;
    assign unused_key = bus.key_id[KEY_ID_W-1:0];
    assign hit        = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        core_next_d = state_q == S_LD_TEXT;
        case (state_q)
            S_IDLE: if (arb_any) begin
                grant_d = arb_gnt;
                sel_d   = arb_idx;
                state_d = hit ? S_LD_TEXT : S_LD_KEY;
            end
            S_LD_KEY:   state_d = S_KINIT;
            S_KINIT:    state_d = S_WAIT_KEY;
            S_WAIT_KEY: state_d = bus.core_ready ? S_LD_TEXT : S_WAIT_KEY;
            S_LD_TEXT:  state_d = S_WAIT_CIPHER;
            S_WAIT_CIPHER: if (bus.core_valid) begin
                state_d = S_IDLE;
                grant_d = '0;
                sel_d   = '0;
                ptr_d   = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + IW'(1);
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            ptr_q       <= '0;
            core_next_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            core_next_q <= core_next_d;
        end
    end
    // done is combinational so the owner can drop req before the arbiter samples it again
    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.done      = (state_q == S_WAIT_CIPHER && bus.core_valid) ? grant_q : '0;
    assign bus.en_key    = state_q == S_LD_KEY;
    assign bus.core_init = state_q == S_KINIT;
    assign bus.en_data   = state_q == S_LD_TEXT;
    assign bus.core_next = core_next_q;
endmodule
